qdr_phase_select: RTL and testbench



---
 rtl/qdr_phase_pkg.sv | 20 ++
 rtl/qdr_phase_tcount.sv | 44 ++++
 rtl/qdr_phase_select.sv | 148 ++++++++++++++
 tb/tb_qdr_phase_select.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/qdr_phase_pkg.sv
// Shared types and width helpers for the QDR phase-selection stage.
package qdr_phase_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, COMPARE, DONE} phase_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Enough headroom for (2^win_log2 - 1) * width transitions.
  function automatic int cnt_width(input int win_log2, input int width);
    return win_log2 + clog2(width + 1);
  endfunction

endpackage

// File: rtl/qdr_phase_tcount.sv
// Per-phase transition counter: remembers the previous sample and
// accumulates the number of bits that toggled since then.
module qdr_phase_tcount
  import qdr_phase_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             first,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] pop;

  always_comb begin
    diff = data ^ prev_reg;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(diff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prev_reg <= '0;
      cnt_reg  <= '0;
    end else if (en) begin
      prev_reg <= data;
      // The first window cycle only primes prev_reg.
      if (!first) cnt_reg <= cnt_reg + pop;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/qdr_phase_select.sv
// Trains on per-phase transition counts, locks onto the quietest phase
// and forwards that phase's sample; manual override bypasses training.
module qdr_phase_select
  import qdr_phase_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NPHASE   = 4,
  parameter int WIN_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPHASE*WIDTH-1:0]   data_in,
  input  logic                      train,
  input  logic                      manual_en,
  input  logic [clog2(NPHASE)-1:0]  manual_sel,
  output logic [WIDTH-1:0]          data_out,
  output logic                      data_valid,
  output logic [clog2(NPHASE)-1:0]  sel,
  output logic                      busy,
  output logic                      locked,
  output logic                      no_activity
);

  localparam int SEL_W = clog2(NPHASE);
  localparam int CNT_W = cnt_width(WIN_LOG2, WIDTH);

  phase_state_t state_reg, state_next;

  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [SEL_W-1:0]    cmp_idx_reg;
  logic [CNT_W-1:0]    min_cnt_reg;
  logic [SEL_W-1:0]    min_idx_reg;
  logic                any_nz_reg;
  logic [SEL_W-1:0]    trained_sel_reg;
  logic                locked_reg;
  logic                no_act_reg;
  logic [WIDTH-1:0]    data_out_reg;
  logic                data_valid_reg;

  logic [WIDTH-1:0] phase_data [NPHASE];
  logic [CNT_W-1:0] cnt        [NPHASE];
  logic [CNT_W-1:0] cur_cnt;
  logic [SEL_W-1:0] eff_sel;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_first;

  assign cnt_clr   = (state_reg == CLEAR);
  assign cnt_en    = (state_reg == COUNT);
  assign cnt_first = (win_cnt_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NPHASE; gi++) begin : g_phase
      assign phase_data[gi] = data_in[gi*WIDTH +: WIDTH];

      qdr_phase_tcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_tcount (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .first (cnt_first),
        .data  (phase_data[gi]),
        .cnt   (cnt[gi])
      );
    end
  endgenerate

  assign cur_cnt = cnt[cmp_idx_reg];
  assign eff_sel = manual_en ? manual_sel : trained_sel_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (train && !manual_en) state_next = CLEAR;
      CLEAR:   state_next = COUNT;
      COUNT:   if (win_cnt_reg == '1) state_next = COMPARE;
      COMPARE: if (cmp_idx_reg == SEL_W'(NPHASE - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_reg     <= '0;
      cmp_idx_reg     <= '0;
      min_cnt_reg     <= '0;
      min_idx_reg     <= '0;
      any_nz_reg      <= 1'b0;
      trained_sel_reg <= '0;
      locked_reg      <= 1'b0;
      no_act_reg      <= 1'b0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
    end else begin
      data_out_reg   <= phase_data[eff_sel];
      data_valid_reg <= locked_reg | manual_en;
      case (state_reg)
        CLEAR: begin
          win_cnt_reg <= '0;
          cmp_idx_reg <= '0;
          // All-ones start guarantees phase 0 is always taken first.
          min_cnt_reg <= '1;
          min_idx_reg <= '0;
          any_nz_reg  <= 1'b0;
          locked_reg  <= 1'b0;
        end
        COUNT: win_cnt_reg <= win_cnt_reg + 1'b1;
        COMPARE: begin
          if (cur_cnt < min_cnt_reg) begin
            min_cnt_reg <= cur_cnt;
            min_idx_reg <= cmp_idx_reg;
          end
          if (cur_cnt != '0) any_nz_reg <= 1'b1;
          cmp_idx_reg <= cmp_idx_reg + 1'b1;
        end
        DONE: begin
          if (any_nz_reg) begin
            trained_sel_reg <= min_idx_reg;
            locked_reg      <= 1'b1;
            no_act_reg      <= 1'b0;
          end else begin
            locked_reg <= 1'b0;
            no_act_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign sel         = eff_sel;
  assign busy        = (state_reg != IDLE);
  assign locked      = locked_reg;
  assign no_activity = no_act_reg;

endmodule

// File: tb/tb_qdr_phase_select.sv
// Directed bench for qdr_phase_select: manual-select table plus
// hand-written training sequences (winner, tie, idle bus, reset abort).
module tb_qdr_phase_select;

  localparam int WIDTH    = 8;
  localparam int NPHASE   = 4;
  localparam int WIN_LOG2 = 4;
  localparam int LAT      = 23;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        train;
  logic        manual_en;
  logic [1:0]  manual_sel;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  sel;
  logic        busy;
  logic        locked;
  logic        no_activity;

  qdr_phase_select #(
    .WIDTH    (WIDTH),
    .NPHASE   (NPHASE),
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .train       (train),
    .manual_en   (manual_en),
    .manual_sel  (manual_sel),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .sel         (sel),
    .busy        (busy),
    .locked      (locked),
    .no_activity (no_activity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        me;
    logic [1:0]  ms;
    logic [31:0] din;
    logic [7:0]  exp_out;
    logic [1:0]  exp_sel;
    logic        exp_valid;
  } vec_t;

  vec_t        vecs [5];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mode     = 0;   // 0 static, 1 winner pattern, 2 tie pattern
  logic        tog      = 1'b0;
  logic [31:0] static_word = 32'h0;
  int          blen;

  function automatic logic [31:0] gen(input int m, input logic t, input logic [31:0] sw);
    logic [7:0] alt;
    alt = t ? 8'hFF : 8'h00;
    case (m)
      1:       return {8'hA5, {7'b0, t}, alt, alt};
      2:       return {8'h22, (t ? 8'hF0 : 8'h0F), 8'h11, (t ? 8'hF0 : 8'h0F)};
      default: return sw;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Advance one cycle, refresh the stimulus pattern, let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
    tog     = ~tog;
    data_in = gen(mode, tog, static_word);
    #1;
  endtask

  // Pulse train and return the cycle offset where busy first reads 0.
  task automatic run_train(output int len);
    tick();
    train = 1'b1;
    len   = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      train = 1'b0;
      if (!busy) begin
        len = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; train = 1'b0; manual_en = 1'b0; manual_sel = 2'd0; data_in = '0;

    vecs[0] = '{1'b1, 2'd2, 32'h445A2211, 8'h5A, 2'd2, 1'b1};
    vecs[1] = '{1'b1, 2'd0, 32'h445A2211, 8'h11, 2'd0, 1'b1};
    vecs[2] = '{1'b1, 2'd3, 32'hC3B2A190, 8'hC3, 2'd3, 1'b1};
    vecs[3] = '{1'b0, 2'd3, 32'h0F1E2D3C, 8'h3C, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 32'h77665544, 8'h55, 2'd1, 1'b1};

    tick(); tick();
    reset = 1'b0;
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst data_valid", 32'(data_valid), 32'h0);
    check("rst sel", 32'(sel), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst locked", 32'(locked), 32'h0);
    check("rst no_activity", 32'(no_activity), 32'h0);

    // Manual-select table: sel is immediate, data_out/data_valid one cycle later.
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      manual_en   = vecs[i].me;
      manual_sel  = vecs[i].ms;
      static_word = vecs[i].din;
      data_in     = vecs[i].din;
      #1;
      check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      tick();
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d data_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
    end
    manual_en = 1'b0;

    // Clear winner: phase 3 is constant.
    mode = 1;
    run_train(blen);
    check("winner busy length", 32'(blen), 32'(LAT));
    check("winner sel", 32'(sel), 32'd3);
    check("winner locked", 32'(locked), 32'd1);
    check("winner no_activity", 32'(no_activity), 32'd0);
    tick();
    check("winner data_out", 32'(data_out), 32'hA5);
    check("winner data_valid", 32'(data_valid), 32'd1);

    // Idle bus after a lock: sel must hold at 3.
    mode = 0; static_word = 32'h3C3C3C3C;
    run_train(blen);
    check("idle busy length", 32'(blen), 32'(LAT));
    check("idle no_activity", 32'(no_activity), 32'd1);
    check("idle locked", 32'(locked), 32'd0);
    check("idle sel", 32'(sel), 32'd3);
    tick();
    check("idle data_valid", 32'(data_valid), 32'd0);

    // Tie between phases 1 and 3 resolves to the lower index.
    mode = 2;
    run_train(blen);
    check("tie busy length", 32'(blen), 32'(LAT));
    check("tie sel", 32'(sel), 32'd1);
    check("tie locked", 32'(locked), 32'd1);
    check("tie no_activity", 32'(no_activity), 32'd0);

    // Reset five cycles into a run, then a clean run.
    mode = 1;
    tick();
    train = 1'b1;
    tick();
    train = 1'b0;
    tick(); tick(); tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sel", 32'(sel), 32'd0);
    check("abort locked", 32'(locked), 32'd0);
    check("abort data_valid", 32'(data_valid), 32'd0);
    run_train(blen);
    check("retrain busy length", 32'(blen), 32'(LAT));
    check("retrain sel", 32'(sel), 32'd3);
    check("retrain locked", 32'(locked), 32'd1);

    // Manual override with a train pulse that must be ignored.
    mode = 0; static_word = 32'h445A2211;
    tick();
    manual_en = 1'b1; manual_sel = 2'd2; train = 1'b1;
    #1;
    check("manual sel", 32'(sel), 32'd2);
    tick();
    train = 1'b0;
    check("manual data_out", 32'(data_out), 32'h5A);
    check("manual data_valid", 32'(data_valid), 32'd1);
    check("manual busy t+1", 32'(busy), 32'd0);
    tick(); tick();
    check("manual busy t+3", 32'(busy), 32'd0);
    manual_en = 1'b0;
    #1;
    check("manual release sel", 32'(sel), 32'd3);
    tick();
    check("manual release data_out", 32'(data_out), 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
